axis_packet_arbiter: RTL

- Packet-atomic round-robin arbiter. Shares one AXI-Stream injection port (one NoC router input shim) among NUM_REQ user-side requesters.
- Once a requester is granted, it owns the output until its tlast beat transfers. Packets from different requesters never interleave.
- Sits in the user clock domain, between user masters and an axis_serializer_shim_in.
- Output carries the requester index so the far end can identify the source.

---
 rtl/axis_packet_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI-Stream port among NUM_REQ requesters.
// Optional 2-entry output skid slice enabled by defining AXIS_PACKET_ARBITER_OUTPUT_REG_EN.
module axis_packet_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int IDX_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      in_tvalid,
  output logic [NUM_REQ-1:0]                      in_tready,
  input  logic [NUM_REQ-1:0][TDATA_WIDTH-1:0]     in_tdata,
  input  logic [NUM_REQ-1:0]                      in_tlast,
  input  logic [NUM_REQ-1:0][TDEST_WIDTH-1:0]     in_tdest,
  output logic                                    out_tvalid,
  input  logic                                    out_tready,
  output logic [TDATA_WIDTH-1:0]                  out_tdata,
  output logic                                    out_tlast,
  output logic [TID_WIDTH-1:0]                    out_tid,
  output logic [TDEST_WIDTH-1:0]                  out_tdest,
  output logic [IDX_WIDTH-1:0]                    grant_idx,
  output logic                                    busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           r_state;
  logic [IDX_WIDTH-1:0] r_rr_ptr;
  logic [IDX_WIDTH-1:0] r_lock_idx;
  logic [IDX_WIDTH-1:0] w_search_sel;
  logic [IDX_WIDTH-1:0] w_sel;
  logic                 w_fwd_valid;
  logic                 w_fwd_ready;
  logic                 w_fwd_last;
  logic                 w_xfer;

  // Explicit wrap so non-power-of-2 requester counts never index past the last requester.
  function automatic logic [IDX_WIDTH-1:0] idx_add(input logic [IDX_WIDTH-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_WIDTH'(sum);
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    logic                 found;
    logic [IDX_WIDTH-1:0] cand;
    w_search_sel = r_rr_ptr;
    found        = 1'b0;
    cand         = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = idx_add(r_rr_ptr, k);
      if (!found && in_tvalid[cand]) begin
        w_search_sel = cand;
        found        = 1'b1;
      end
    end
  end

  assign w_sel       = rst ? '0 : ((r_state == ST_LOCKED) ? r_lock_idx : w_search_sel);
  assign w_fwd_valid = !rst && in_tvalid[w_sel];
  assign w_fwd_last  = in_tlast[w_sel];
  assign w_xfer      = w_fwd_valid && w_fwd_ready;
  assign grant_idx   = w_sel;
  assign busy        = !rst && (r_state == ST_LOCKED);

  always_comb begin
    in_tready = '0;
    if (!rst) in_tready[w_sel] = w_fwd_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
    end else if (w_xfer) begin
      if (w_fwd_last) begin
        r_state  <= ST_IDLE;
        r_rr_ptr <= idx_add(w_sel, 1);
      end else begin
        r_state    <= ST_LOCKED;
        r_lock_idx <= w_sel;
      end
    end
  end

`ifdef AXIS_PACKET_ARBITER_OUTPUT_REG_EN
  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic                   last;
    logic [TID_WIDTH-1:0]   id;
    logic [TDEST_WIDTH-1:0] dest;
  } beat_t;

  beat_t w_in_beat;
  beat_t r_main;
  beat_t r_skid;
  logic  r_main_valid;
  logic  r_skid_valid;
  logic  w_out_pop;

  assign w_in_beat   = '{data: in_tdata[w_sel], last: w_fwd_last,
                         id: TID_WIDTH'(w_sel), dest: in_tdest[w_sel]};
  // Ready toward the requesters comes from the skid flag alone, breaking the out_tready path.
  assign w_fwd_ready = !r_skid_valid;
  assign w_out_pop   = r_main_valid && out_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_out_pop) r_skid_valid <= 1'b0;
    end else if (w_xfer) begin
      if (r_main_valid && !out_tready) r_skid_valid <= 1'b1;
      else                             r_main_valid <= 1'b1;
    end else if (w_out_pop) begin
      r_main_valid <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; the valid flags alone define slice contents.
  always_ff @(posedge clk) begin
    if (r_skid_valid) begin
      if (w_out_pop) r_main <= r_skid;
    end else if (w_xfer) begin
      if (r_main_valid && !out_tready) r_skid <= w_in_beat;
      else                             r_main <= w_in_beat;
    end
  end

  assign out_tvalid = !rst && r_main_valid;
  assign out_tdata  = r_main.data;
  assign out_tlast  = r_main.last;
  assign out_tid    = r_main.id;
  assign out_tdest  = r_main.dest;
`else
  assign w_fwd_ready = out_tready;
  assign out_tvalid  = w_fwd_valid;
  assign out_tdata   = in_tdata[w_sel];
  assign out_tlast   = w_fwd_last;
  assign out_tid     = TID_WIDTH'(w_sel);
  assign out_tdest   = in_tdest[w_sel];
`endif

endmodule
